// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - single-cycle integer ALU with CDB broadcast.
// Optional shift-add multiplier enabled by defining ALU_MUL_EN.
module alu_unit #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             RS_S,
  input  logic [5:0]       RS_Op,
  input  logic [31:0]      RS_Vj,
  input  logic [31:0]      RS_Vk,
  input  logic [31:0]      RS_A,
  input  logic [31:0]      RS_pc,
  input  logic [ROB_W-1:0] RS_Reorder,
  output logic             busy,
  output logic             CDB_S,
  output logic [ROB_W-1:0] CDB_Reorder,
  output logic [31:0]      CDB_Value,
  output logic             CDB_jump,
  output logic [31:0]      CDB_target
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

  state_t state;

  logic [31:0] op_b, alu_val, alu_tgt;
  logic        alu_jump, is_mul, is_br, taken, slt_b;

  // Opcodes 0-9 take Vk, 16-25 are the same ops with the immediate as operand b.
  always_comb begin
    alu_val  = '0;
    alu_jump = 1'b0;
    alu_tgt  = '0;
    is_mul   = 1'b0;
    is_br    = 1'b0;
    taken    = 1'b0;
    op_b     = RS_Op[4] ? RS_A : RS_Vk;
    slt_b    = $signed(RS_Vj) < $signed(op_b);
    if (!RS_Op[5]) begin
      case (RS_Op[3:0])
        4'd0:    alu_val = RS_Vj + op_b;
        4'd1:    alu_val = RS_Vj - op_b;
        4'd2:    alu_val = RS_Vj & op_b;
        4'd3:    alu_val = RS_Vj | op_b;
        4'd4:    alu_val = RS_Vj ^ op_b;
        4'd5:    alu_val = RS_Vj << op_b[4:0];
        4'd6:    alu_val = RS_Vj >> op_b[4:0];
        4'd7:    alu_val = $signed(RS_Vj) >>> op_b[4:0];
        4'd8:    alu_val = {31'b0, slt_b};
        4'd9:    alu_val = {31'b0, RS_Vj < op_b};
        default: ;
      endcase
    end else begin
      case (RS_Op[4:0])
        5'd0: alu_val = RS_A;
        5'd1: alu_val = RS_pc + RS_A;
        5'd2: begin
          alu_val  = RS_pc + 32'd4;
          alu_jump = 1'b1;
          alu_tgt  = RS_pc + RS_A;
        end
        5'd3: begin
          alu_val  = RS_pc + 32'd4;
          alu_jump = 1'b1;
          alu_tgt  = (RS_Vj + RS_A) & ~32'd1;
        end
        5'd4: begin is_br = 1'b1; taken = (RS_Vj == RS_Vk); end
        5'd5: begin is_br = 1'b1; taken = (RS_Vj != RS_Vk); end
        5'd6: begin is_br = 1'b1; taken = ($signed(RS_Vj) < $signed(RS_Vk)); end
        5'd7: begin is_br = 1'b1; taken = ($signed(RS_Vj) >= $signed(RS_Vk)); end
        5'd8: begin is_br = 1'b1; taken = (RS_Vj < RS_Vk); end
        5'd9: begin is_br = 1'b1; taken = (RS_Vj >= RS_Vk); end
`ifdef ALU_MUL_EN
        5'd10: is_mul = 1'b1;
`endif
        default: ;
      endcase
    end
    if (is_br) begin
      alu_jump = taken;
      alu_tgt  = taken ? (RS_pc + RS_A) : (RS_pc + 32'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      CDB_S       <= 1'b0;
      CDB_Reorder <= '0;
      CDB_Value   <= '0;
      CDB_jump    <= 1'b0;
      CDB_target  <= '0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else if (rdy) begin
      if (clr) begin
        state <= IDLE;
        busy  <= 1'b0;
        CDB_S <= 1'b0;
      end else begin
        case (state)
`ifdef ALU_MUL_EN
          // One multiplier bit per cycle; the 32nd step writes the CDB directly.
          MUL: begin
            acc    <= acc + (mplier[0] ? mcand : 32'd0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state      <= DONE;
              busy       <= 1'b0;
              CDB_S      <= 1'b1;
              CDB_Value  <= acc + (mplier[0] ? mcand : 32'd0);
              CDB_jump   <= 1'b0;
              CDB_target <= '0;
            end
          end
`endif
          default: begin
            if (RS_S && is_mul) begin
`ifdef ALU_MUL_EN
              state       <= MUL;
              busy        <= 1'b1;
              CDB_S       <= 1'b0;
              CDB_Reorder <= RS_Reorder;
              mcand       <= RS_Vj;
              mplier      <= RS_Vk;
              acc         <= '0;
              cnt         <= '0;
`endif
            end else if (RS_S) begin
              state       <= DONE;
              CDB_S       <= 1'b1;
              CDB_Reorder <= RS_Reorder;
              CDB_Value   <= alu_val;
              CDB_jump    <= alu_jump;
              CDB_target  <= alu_tgt;
            end else begin
              state <= IDLE;
              CDB_S <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed and randomized checks of alu_unit against a reference model.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, RS_S;
  logic [5:0]  RS_Op;
  logic [31:0] RS_Vj, RS_Vk, RS_A, RS_pc;
  logic [3:0]  RS_Reorder;
  logic        busy, CDB_S, CDB_jump;
  logic [3:0]  CDB_Reorder;
  logic [31:0] CDB_Value, CDB_target;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] v;
    logic        j;
    logic [31:0] t;
  } res_t;

  alu_unit #(.ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .RS_S(RS_S), .RS_Op(RS_Op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_A(RS_A), .RS_pc(RS_pc), .RS_Reorder(RS_Reorder),
    .busy(busy), .CDB_S(CDB_S), .CDB_Reorder(CDB_Reorder),
    .CDB_Value(CDB_Value), .CDB_jump(CDB_jump), .CDB_target(CDB_target)
  );

  always #5 clk = ~clk;

  // Reference: what each instruction means architecturally.
  function automatic res_t model(input int op, input logic [31:0] vj, vk, a, pc);
    res_t r;
    logic [31:0] b;
    int base;
    logic tk;
    r = '0;
    tk = 1'b0;
    b = (op >= 16 && op < 32) ? a : vk;
    base = op % 16;
    if (op < 32 && base < 10) begin
      case (base)
        0: r.v = vj + b;
        1: r.v = vj - b;
        2: r.v = vj & b;
        3: r.v = vj | b;
        4: r.v = vj ^ b;
        5: r.v = vj << (b % 32);
        6: r.v = vj >> (b % 32);
        7: r.v = $signed(vj) >>> (b % 32);
        8: r.v = ($signed(vj) < $signed(b)) ? 32'd1 : 32'd0;
        default: r.v = (vj < b) ? 32'd1 : 32'd0;
      endcase
    end else if (op == 32) r.v = a;
    else if (op == 33) r.v = pc + a;
    else if (op == 34) begin r.v = pc + 4; r.j = 1'b1; r.t = pc + a; end
    else if (op == 35) begin r.v = pc + 4; r.j = 1'b1; r.t = (vj + a) & 32'hFFFF_FFFE; end
    else if (op >= 36 && op <= 41) begin
      case (op)
        36: tk = (vj == vk);
        37: tk = (vj != vk);
        38: tk = ($signed(vj) < $signed(vk));
        39: tk = !($signed(vj) < $signed(vk));
        40: tk = (vj < vk);
        default: tk = !(vj < vk);
      endcase
      r.j = tk;
      r.t = tk ? pc + a : pc + 4;
    end
`ifdef ALU_MUL_EN
    else if (op == 42) r.v = vj * vk;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input logic [31:0] vj, vk, a, pc, input logic [3:0] tag);
    RS_S = 1'b1; RS_Op = op[5:0]; RS_Vj = vj; RS_Vk = vk; RS_A = a; RS_pc = pc; RS_Reorder = tag;
  endtask

  task automatic check_result(input string tag, input res_t r, input logic [3:0] rob);
    chk({tag, ".S"}, 32'(CDB_S), 32'd1);
    chk({tag, ".rob"}, 32'(CDB_Reorder), 32'(rob));
    chk({tag, ".val"}, CDB_Value, r.v);
    chk({tag, ".jump"}, 32'(CDB_jump), 32'(r.j));
    chk({tag, ".tgt"}, CDB_target, r.t);
  endtask

  initial begin
    res_t m;
    int op;
    logic [31:0] vj, vk, a, pc;
    logic [3:0] tag;
    bit seen;

    // reset dominates clr, rdy and a pending issue
    rst = 1'b1; rdy = 1'b0; clr = 1'b1;
    issue(0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd5);
    tick(); tick();
    chk("rst.S", 32'(CDB_S), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.val", CDB_Value, 32'd0);
    chk("rst.rob", 32'(CDB_Reorder), 32'd0);
    chk("rst.jump", 32'(CDB_jump), 32'd0);
    chk("rst.tgt", CDB_target, 32'd0);
    rst = 1'b0; rdy = 1'b1; clr = 1'b0; RS_S = 1'b0;
    tick();
    chk("idle.S", 32'(CDB_S), 32'd0);

    issue(0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
    tick(); RS_S = 1'b0;
    check_result("add", '{v: 32'd12, j: 1'b0, t: 32'd0}, 4'd3);
    tick();
    chk("add.pulse_end", 32'(CDB_S), 32'd0);

    issue(38, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5);
    tick();
    check_result("blt", '{v: 32'd0, j: 1'b1, t: 32'h120}, 4'd5);
    issue(40, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
    tick();
    check_result("bltu", '{v: 32'd0, j: 1'b0, t: 32'h104}, 4'd6);
    issue(35, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd7);
    tick();
    check_result("jalr", '{v: 32'h44, j: 1'b1, t: 32'h1002}, 4'd7);

    for (int i = 1; i <= 3; i++) begin
      issue(7, 32'h8000_0000, 32'h21, 32'd0, 32'd0, i[3:0]);
      tick();
      check_result("sra_b2b", '{v: 32'hC000_0000, j: 1'b0, t: 32'd0}, i[3:0]);
    end
    RS_S = 1'b0;
    tick();
    chk("sra.pulse_end", 32'(CDB_S), 32'd0);

`ifdef ALU_MUL_EN
    issue(42, 32'h10000, 32'h10003, 32'd0, 32'd0, 4'd9);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk("mul.busy", 32'(busy), 32'd1);
      chk("mul.noS", 32'(CDB_S), 32'd0);
      if (i == 5) issue(0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
      else RS_S = 1'b0;
      tick();
    end
    check_result("mul", '{v: 32'h0003_0000, j: 1'b0, t: 32'd0}, 4'd9);
    chk("mul.busy_done", 32'(busy), 32'd0);
    tick();
    chk("mul.pulse_end", 32'(CDB_S), 32'd0);

    issue(42, 32'd3, 32'd4, 32'd0, 32'd0, 4'd2);
    tick(); RS_S = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk("mulclr.busy", 32'(busy), 32'd0);
    chk("mulclr.S", 32'(CDB_S), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (CDB_S) seen = 1'b1; end
    chk("mulclr.no_bcast", 32'(seen), 32'd0);

    issue(42, 32'd3, 32'd4, 32'd0, 32'd0, 4'd2);
    tick(); RS_S = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mulrst.busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin tick(); if (CDB_S) seen = 1'b1; end
    chk("mulrst.no_bcast", 32'(seen), 32'd0);
`else
    issue(42, 32'h10000, 32'h10003, 32'd7, 32'h80, 4'd9);
    tick(); RS_S = 1'b0;
    check_result("mul_unknown", '{v: 32'd0, j: 1'b0, t: 32'd0}, 4'd9);
    chk("mul_unknown.busy", 32'(busy), 32'd0);
    tick();
`endif

    issue(0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd4);
    tick();
    chk("clr.pre", 32'(CDB_S), 32'd1);
    clr = 1'b1;
    issue(0, 32'd3, 32'd3, 32'd0, 32'd0, 4'd9);
    tick();
    chk("clr.S", 32'(CDB_S), 32'd0);
    chk("clr.busy", 32'(busy), 32'd0);
    clr = 1'b0; RS_S = 1'b0;
    tick();
    chk("clr.no_late", 32'(CDB_S), 32'd0);

    issue(4, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 4'd6);
    tick();
    check_result("rdy.pre", '{v: 32'h0000_FF00, j: 1'b0, t: 32'd0}, 4'd6);
    rdy = 1'b0;
    issue(0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd2);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_result("rdy.hold", '{v: 32'h0000_FF00, j: 1'b0, t: 32'd0}, 4'd6);
    end
    rdy = 1'b1; RS_S = 1'b0;
    tick();
    chk("rdy.resume_end", 32'(CDB_S), 32'd0);

    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 63));
`ifdef ALU_MUL_EN
      if (op == 42) op = 1;
`endif
      vj = $urandom(); vk = $urandom(); a = $urandom(); pc = $urandom();
      if (k % 4 == 0) vk = vj;
      tag = 4'($urandom_range(0, 15));
      m = model(op, vj, vk, a, pc);
      issue(op, vj, vk, a, pc, tag);
      tick(); RS_S = 1'b0;
      check_result($sformatf("rand%0d_op%0d", k, op), m, tag);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand.gap", 32'(CDB_S), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
